// File: rtl/rtc_burst_ctrl.sv
// CPU-port controller for a multiplexed address/data RTC bus: single-byte writes
// and burst reads into a local buffer, with per-byte mirror pulses.
module rtc_burst_ctrl #(
    parameter int unsigned T_PHASE   = 10,
    parameter int unsigned BURST_MAX = 16,
    parameter logic [7:0]  PORT_BASE = 8'h00
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   port_id,
    input  logic [7:0]                   in_dato,
    input  logic                         write_strobe,
    input  logic                         k_write_strobe,
    input  logic                         read_strobe,
    output logic [7:0]                   out_dato,
    output logic                         busy,
    output logic                         mirror_we,
    output logic [$clog2(BURST_MAX)-1:0] mirror_idx,
    output logic [7:0]                   mirror_data,
    output logic                         reg_a_d,
    output logic                         reg_cs,
    output logic                         reg_rd,
    output logic                         reg_wr,
    inout  wire  [7:0]                   dato
);

    localparam int unsigned IDX_W = $clog2(BURST_MAX);
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
    localparam int unsigned PH_W  = $clog2(T_PHASE + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_GAP, S_DATA, S_RECOV} state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [7:0]         addr_q, wdata_q;
    logic [CNT_W-1:0]   len_q;
    logic [7:0]         cur_addr_q, cur_addr_d, cur_wdata_q, cur_wdata_d;
    logic               is_read_q, is_read_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cap_q, cap_d, rptr_q, rptr_d;
    logic [IDX_W-1:0]   wptr_q, wptr_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               a_d_q, cs_q, rd_q, wr_q, oe_q;
    logic [7:0]         dout_q;
    logic               mirror_we_q;
    logic [IDX_W-1:0]   mirror_idx_q;
    logic [7:0]         mirror_data_q, out_dato_q;
    logic [7:0]         buf_q [BURST_MAX];

    logic               cpu_wr_c, cmd_wr_c, phase_end_c, sample_c;
    logic [7:0]         offset_c, rd_mux_c;
    logic [CNT_W-1:0]   len_clamp_c;

    assign cpu_wr_c    = write_strobe | k_write_strobe;
    assign offset_c    = port_id - PORT_BASE;
    assign cmd_wr_c    = cpu_wr_c && (offset_c == 8'd2);
    assign phase_end_c = (ph_q == PH_W'(T_PHASE - 1));

    // Length register: 0 means one byte, oversize requests clamp to the buffer depth
    assign len_clamp_c = (in_dato == 8'd0) ? CNT_W'(1) :
                         ({1'b0, in_dato} > 9'(BURST_MAX)) ? CNT_W'(BURST_MAX) :
                         CNT_W'(in_dato);

    // Next-state logic for the bus sequencer and transaction bookkeeping
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        is_read_d   = is_read_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        sample_c    = 1'b0;

        if (read_strobe && (offset_c == 8'd1) && (rptr_q < cap_q))
            rptr_d = rptr_q + CNT_W'(1);
        if (cmd_wr_c && busy_q)
            err_d = 1'b1;
        if (state_q != S_IDLE)
            ph_d = phase_end_c ? '0 : ph_q + PH_W'(1);

        case (state_q)
            S_IDLE: begin
                if (cmd_wr_c && (in_dato[1] || in_dato[0])) begin
                    state_d     = S_ADDR;
                    ph_d        = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    cur_addr_d  = addr_q;
                    cur_wdata_d = wdata_q;
                    is_read_d   = in_dato[1];
                    cnt_d       = in_dato[1] ? len_q : CNT_W'(1);
                    cap_d       = '0;
                    rptr_d      = '0;
                    wptr_d      = '0;
                end
            end
            S_ADDR:  if (phase_end_c) state_d = S_GAP;
            S_GAP:   if (phase_end_c) state_d = S_DATA;
            S_DATA: begin
                if (phase_end_c) begin
                    state_d = S_RECOV;
                    if (is_read_q) begin
                        sample_c = 1'b1;
                        cap_d    = cap_q + CNT_W'(1);
                    end
                end
            end
            S_RECOV: begin
                if (phase_end_c) begin
                    if (is_read_q && (cap_q < cnt_q)) begin
                        state_d    = S_ADDR;
                        cur_addr_d = cur_addr_q + 8'd1;
                        wptr_d     = wptr_q + IDX_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux_c = 8'h00;
        case (offset_c)
            8'd0: rd_mux_c = {5'b0, err_q, busy_q, done_q};
            8'd1: rd_mux_c = (rptr_q < cap_q) ? buf_q[rptr_q[IDX_W-1:0]] : 8'h00;
            8'd2: rd_mux_c = busy_q ? cur_addr_q : addr_q;
            default: rd_mux_c = 8'h00;
        endcase
    end

    // Bus strobes and output enable are registered from the next state so they never glitch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ph_q          <= '0;
            addr_q        <= 8'h00;
            wdata_q       <= 8'h00;
            len_q         <= CNT_W'(1);
            cur_addr_q    <= 8'h00;
            cur_wdata_q   <= 8'h00;
            is_read_q     <= 1'b0;
            cnt_q         <= '0;
            cap_q         <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            a_d_q         <= 1'b1;
            cs_q          <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            oe_q          <= 1'b0;
            dout_q        <= 8'h00;
            mirror_we_q   <= 1'b0;
            mirror_idx_q  <= '0;
            mirror_data_q <= 8'h00;
            out_dato_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            is_read_q   <= is_read_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cs_q        <= !((state_d == S_ADDR) || (state_d == S_DATA));
            a_d_q       <= (state_d != S_ADDR);
            wr_q        <= !((state_d == S_ADDR) || ((state_d == S_DATA) && !is_read_d));
            rd_q        <= !((state_d == S_DATA) && is_read_d);
            oe_q        <= (state_d == S_ADDR) || ((state_d == S_DATA) && !is_read_d);
            dout_q      <= (state_d == S_DATA) ? cur_wdata_d : cur_addr_d;
            mirror_we_q <= sample_c;
            if (sample_c) begin
                mirror_idx_q  <= wptr_q;
                mirror_data_q <= dato;
            end
            if (cpu_wr_c) begin
                case (offset_c)
                    8'd0: addr_q  <= in_dato;
                    8'd1: wdata_q <= in_dato;
                    8'd3: len_q   <= len_clamp_c;
                    default: ;
                endcase
            end
            out_dato_q <= rd_mux_c;
        end
    end

    // Capture buffer has no reset; its contents are don't-care after an abort
    always_ff @(posedge clk) begin
        if (sample_c)
            buf_q[wptr_q] <= dato;
    end

    assign dato        = oe_q ? dout_q : 8'hzz;
    assign out_dato    = out_dato_q;
    assign busy        = busy_q;
    assign mirror_we   = mirror_we_q;
    assign mirror_idx  = mirror_idx_q;
    assign mirror_data = mirror_data_q;
    assign reg_a_d     = a_d_q;
    assign reg_cs      = cs_q;
    assign reg_rd      = rd_q;
    assign reg_wr      = wr_q;

endmodule

// File: tb/tb_rtc_burst_ctrl.sv
// Directed bench for rtc_burst_ctrl with a simple address-latching RTC model on the bus.
module tb_rtc_burst_ctrl;

    localparam int unsigned T_PHASE   = 2;
    localparam int unsigned BURST_MAX = 16;
    localparam logic [7:0]  PORT_BASE = 8'h00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] in_dato = 8'h00;
    logic       write_strobe = 1'b0;
    logic       k_write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] out_dato;
    logic       busy, mirror_we, reg_a_d, reg_cs, reg_rd, reg_wr;
    logic [3:0] mirror_idx;
    logic [7:0] mirror_data;
    wire  [7:0] dato;

    int errors = 0;
    int checks = 0;

    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_addr = 8'h00;

    int         n_pulse, n_addr, n_rd, busy_cycles, last_idx;
    bit         timed_out;
    int         mir_cyc [32];
    logic [3:0] mir_idx [32];
    logic [7:0] mir_dat [32];
    logic [7:0] adr_log [32];
    logic [7:0] od_log  [64];

    rtc_burst_ctrl #(.T_PHASE(T_PHASE), .BURST_MAX(BURST_MAX), .PORT_BASE(PORT_BASE)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .in_dato(in_dato),
        .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
        .out_dato(out_dato), .busy(busy), .mirror_we(mirror_we), .mirror_idx(mirror_idx),
        .mirror_data(mirror_data), .reg_a_d(reg_a_d), .reg_cs(reg_cs), .reg_rd(reg_rd),
        .reg_wr(reg_wr), .dato(dato)
    );

    // Undriven bus reads as 8'hFF
    pullup pu_dato (dato);

    // RTC model: latch address during the address phase, drive data while RD is low
    assign dato = (reg_rd === 1'b0) ? rtc_mem[rtc_addr] : 8'hzz;
    always @(posedge clk) if (reg_cs === 1'b0 && reg_a_d === 1'b0) rtc_addr <= dato;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic [7:0] off, input logic [7:0] d, input bit k = 1'b0);
        port_id = PORT_BASE + off;
        in_dato = d;
        if (k) k_write_strobe = 1'b1; else write_strobe = 1'b1;
        @(negedge clk);
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] off, input bit strb, output logic [7:0] d);
        port_id     = PORT_BASE + off;
        read_strobe = strb;
        @(negedge clk);
        read_strobe = 1'b0;
        d = out_dato;
    endtask

    // Records bus activity each cycle until busy drops or the budget runs out
    task automatic monitor(input int budget);
        bit prev_ad = 1'b0;
        bit ad_now;
        int k = 0;
        n_pulse = 0; n_addr = 0; n_rd = 0; busy_cycles = -1; last_idx = -1; timed_out = 1'b1;
        while (k < budget) begin
            if (!busy) begin
                busy_cycles = k;
                timed_out   = 1'b0;
                break;
            end
            if (mirror_we) begin
                if (n_pulse < 32) begin
                    mir_cyc[n_pulse] = k;
                    mir_idx[n_pulse] = mirror_idx;
                    mir_dat[n_pulse] = mirror_data;
                end
                last_idx = int'(mirror_idx);
                n_pulse++;
            end
            ad_now = (reg_cs == 1'b0) && (reg_a_d == 1'b0);
            if (ad_now && !prev_ad && n_addr < 32) begin
                adr_log[n_addr] = dato;
                n_addr++;
            end
            prev_ad = ad_now;
            if (!reg_rd) n_rd++;
            if (k < 64) od_log[k] = out_dato;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset_idle();
        logic [7:0] st;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({reg_a_d, reg_cs, reg_rd, reg_wr} !== 4'hF) begin
            errors++; $display("FAIL reset_idle_strobes: got %b expected 1111", {reg_a_d, reg_cs, reg_rd, reg_wr});
        end
        checks++;
        if (dato !== 8'hFF) begin errors++; $display("FAIL reset_idle_bus_z: got %h expected ff (released)", dato); end
        checks++;
        if ({busy, mirror_we, out_dato} !== 10'h000) begin
            errors++; $display("FAIL reset_idle_outputs: busy=%b mirror_we=%b out_dato=%h expected 0/0/00", busy, mirror_we, out_dato);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h00) begin errors++; $display("FAIL reset_idle_status: got %h expected 00", st); end
    endtask

    task automatic test_single_write();
        logic [3:0] exp_s;
        logic [7:0] exp_d;
        logic [7:0] st;
        cpu_write(8'd0, 8'h21);
        cpu_write(8'd1, 8'h45);
        cpu_write(8'd2, 8'h01);
        for (int k = 0; k <= 8; k++) begin
            case (k / 2)
                0:       begin exp_s = 4'b0010; exp_d = 8'h21; end
                2:       begin exp_s = 4'b1010; exp_d = 8'h45; end
                default: begin exp_s = 4'b1111; exp_d = 8'hFF; end
            endcase
            checks++;
            if ({reg_a_d, reg_cs, reg_rd, reg_wr} !== exp_s) begin
                errors++; $display("FAIL write_strobes k=%0d: got %b expected %b", k, {reg_a_d, reg_cs, reg_rd, reg_wr}, exp_s);
            end
            checks++;
            if (dato !== exp_d) begin errors++; $display("FAIL write_bus k=%0d: got %h expected %h", k, dato, exp_d); end
            checks++;
            if (busy !== (k < 8)) begin errors++; $display("FAIL write_busy k=%0d: got %b expected %b", k, busy, (k < 8)); end
            @(negedge clk);
        end
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL write_status: got %h expected 01", st); end
    endtask

    task automatic test_burst_read();
        logic [7:0] rd;
        logic [7:0] exp_b [4] = '{8'h10, 8'h20, 8'h30, 8'h00};
        cpu_write(8'd0, 8'h21);
        cpu_write(8'd3, 8'd3);
        cpu_write(8'd2, 8'h02);
        port_id = PORT_BASE + 8'd1;
        monitor(100);
        checks++;
        if (timed_out || busy_cycles != 24) begin
            errors++; $display("FAIL burst_busy_len: got %0d cycles (timeout=%0b) expected 24", busy_cycles, timed_out);
        end
        checks++;
        if (n_pulse != 3) begin errors++; $display("FAIL burst_pulse_count: got %0d expected 3", n_pulse); end
        for (int i = 0; i < 3 && i < n_pulse; i++) begin
            checks++;
            if (mir_idx[i] !== 4'(i) || mir_dat[i] !== exp_b[i] || mir_cyc[i] != 6 + 8 * i) begin
                errors++;
                $display("FAIL burst_mirror[%0d]: got idx=%0d data=%h cyc=%0d expected idx=%0d data=%h cyc=%0d",
                         i, mir_idx[i], mir_dat[i], mir_cyc[i], i, exp_b[i], 6 + 8 * i);
            end
        end
        checks++;
        if (od_log[6] !== 8'h00 || od_log[7] !== 8'h10) begin
            errors++; $display("FAIL burst_partial_read: got %h,%h expected 00,10", od_log[6], od_log[7]);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(8'd1, 1'b1, rd);
            checks++;
            if (rd !== exp_b[i]) begin errors++; $display("FAIL burst_buffer_read[%0d]: got %h expected %h", i, rd, exp_b[i]); end
        end
        cpu_read(8'd0, 1'b0, rd);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL burst_status: got %h expected 01", rd); end
    endtask

    task automatic test_addr_wrap();
        cpu_write(8'd0, 8'hFF);
        cpu_write(8'd3, 8'd2);
        cpu_write(8'd2, 8'h03);
        monitor(100);
        checks++;
        if (n_addr != 2 || adr_log[0] !== 8'hFF || adr_log[1] !== 8'h00) begin
            errors++; $display("FAIL wrap_addr: got n=%0d %h,%h expected 2 ff,00", n_addr, adr_log[0], adr_log[1]);
        end
        checks++;
        if (n_pulse != 2 || mir_dat[0] !== 8'hA5 || mir_dat[1] !== 8'h5A) begin
            errors++; $display("FAIL wrap_data: got n=%0d %h,%h expected 2 a5,5a", n_pulse, mir_dat[0], mir_dat[1]);
        end
    endtask

    task automatic test_length_clamp();
        cpu_write(8'd0, 8'h40);
        cpu_write(8'd3, 8'd0, 1'b1);
        cpu_write(8'd2, 8'h02);
        monitor(60);
        checks++;
        if (busy_cycles != 8 || n_pulse != 1 || last_idx != 0) begin
            errors++; $display("FAIL len_zero: got cycles=%0d pulses=%0d last_idx=%0d expected 8/1/0", busy_cycles, n_pulse, last_idx);
        end
        cpu_write(8'd3, 8'd20);
        cpu_write(8'd2, 8'h02);
        monitor(200);
        checks++;
        if (busy_cycles != 128 || n_pulse != 16 || last_idx != 15) begin
            errors++; $display("FAIL len_over: got cycles=%0d pulses=%0d last_idx=%0d expected 128/16/15", busy_cycles, n_pulse, last_idx);
        end
    endtask

    task automatic test_cmd_while_busy();
        logic [7:0] st;
        int active;
        cpu_write(8'd0, 8'h30);
        cpu_write(8'd1, 8'h77);
        cpu_write(8'd2, 8'h01);
        cpu_write(8'd2, 8'h02);
        monitor(60);
        checks++;
        if (busy_cycles != 7 || n_rd != 0 || n_addr != 1) begin
            errors++; $display("FAIL busy_ignore: got cycles=%0d rd_low=%0d addr_phases=%0d expected 7/0/1", busy_cycles, n_rd, n_addr);
        end
        active = 0;
        for (int k = 0; k < 10; k++) begin
            if ({reg_a_d, reg_cs, reg_rd, reg_wr} != 4'hF || busy) active++;
            @(negedge clk);
        end
        checks++;
        if (active != 0) begin errors++; $display("FAIL busy_no_restart: got %0d active cycles expected 0", active); end
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h05) begin errors++; $display("FAIL busy_err_status: got %h expected 05", st); end
        cpu_write(8'd2, 8'h01);
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h02) begin errors++; $display("FAIL busy_err_cleared: got %h expected 02", st); end
        monitor(60);
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL busy_final_status: got %h expected 01", st); end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] st;
        int active;
        cpu_write(8'd0, 8'h21);
        cpu_write(8'd1, 8'h45);
        cpu_write(8'd2, 8'h01);
        repeat (4) @(negedge clk);
        checks++;
        if (dato !== 8'h45) begin errors++; $display("FAIL mid_data_bus: got %h expected 45", dato); end
        reset = 1'b0;
        #1;
        checks++;
        if ({reg_a_d, reg_cs, reg_rd, reg_wr} !== 4'hF || dato !== 8'hFF) begin
            errors++; $display("FAIL mid_reset_abort: got strobes=%b bus=%h expected 1111/ff", {reg_a_d, reg_cs, reg_rd, reg_wr}, dato);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        active = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if ({reg_a_d, reg_cs, reg_rd, reg_wr} != 4'hF || busy) active++;
        end
        checks++;
        if (active != 0) begin errors++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", active); end
        cpu_read(8'd0, 1'b0, st);
        checks++;
        if (st !== 8'h00) begin errors++; $display("FAIL mid_reset_status: got %h expected 00", st); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'(i) ^ 8'hC3;
        rtc_mem[8'h21] = 8'h10;
        rtc_mem[8'h22] = 8'h20;
        rtc_mem[8'h23] = 8'h30;
        rtc_mem[8'hFF] = 8'hA5;
        rtc_mem[8'h00] = 8'h5A;
        @(negedge clk);
        test_reset_idle();
        test_single_write();
        test_burst_read();
        test_addr_wrap();
        test_length_clamp();
        test_cmd_while_busy();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rtc_burst_ctrl.md
RTC_BURST_CTRL -- requirements
Module: rtc_burst_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- T_PHASE, 10: clock cycles per bus phase, at least 1.
- BURST_MAX, 16: read buffer depth in bytes, power of 2, at most 256.
- PORT_BASE, 8'h00: base CPU port number; 4-aligned.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- port_id  in  8  CPU port number.
- in_dato  in  8  CPU out_port data.
- write_strobe  in  1  CPU write qualifier.
- k_write_strobe  in  1  CPU constant-write qualifier.
- read_strobe  in  1  CPU read qualifier.
- out_dato  out  8  data for the CPU in_port mux.
- busy  out  1  a transaction is in progress.
- mirror_we  out  1  one-cycle pulse per byte read.
- mirror_idx  out  clog2(BURST_MAX)  burst index of the byte read.
- mirror_data  out  8  the byte read.
- reg_a_d, reg_cs, reg_rd, reg_wr  out  1 each  RTC bus strobes, all active-low.
- dato  inout  8  multiplexed RTC address/data bus.

Function
REQ-003 A CPU write SHALL be any cycle where write_strobe or k_write_strobe is 1; the port offset is port_id-PORT_BASE.
REQ-004 CPU writes SHALL act by offset:
- 0: load start address.
- 1: load write data.
- 2: command. bit0 = single write, bit1 = burst read; if both are set, burst read wins.
- 3: burst length. 0 is stored as 1; values above BURST_MAX are stored as BURST_MAX.
REQ-005 A command SHALL be accepted only when busy=0. Acceptance clears done and err, resets the buffer write and read pointers to 0, and sets busy on the next edge.
REQ-006 A command written while busy=1 SHALL be ignored and SHALL set err.
REQ-007 Writes to offsets 0, 1 and 3 while busy SHALL update the registers but SHALL NOT affect the transaction in flight.
REQ-008 The FSM SHALL have states IDLE, ADDR, GAP, DATA, RECOV; each non-IDLE state lasts exactly T_PHASE cycles, counted by a phase counter.
REQ-009 In IDLE, all four strobes SHALL be 1 and dato SHALL be high-Z.
REQ-010 In ADDR, reg_cs=0, reg_a_d=0, reg_wr=0, reg_rd=1, and dato SHALL be driven with the current address.
REQ-011 In GAP and RECOV, all strobes SHALL be 1 and dato SHALL be high-Z.
REQ-012 In DATA for a write: reg_cs=0, reg_a_d=1, reg_wr=0, reg_rd=1, and dato SHALL be driven with the write data.
REQ-013 In DATA for a read: reg_cs=0, reg_a_d=1, reg_rd=0, reg_wr=1, dato SHALL be high-Z, and dato SHALL be sampled on the last DATA cycle.
REQ-014 All strobes and the bus output enable SHALL be registered with no glitches; one byte SHALL take 4*T_PHASE cycles.
REQ-015 On each read sample, the byte SHALL be stored in buffer[wptr], and mirror_we=1, mirror_idx=wptr and mirror_data=byte SHALL be output for one cycle, on the edge after the sample.
REQ-016 At the end of RECOV:
- if bytes remain, the address SHALL increment modulo 256 (0xFF wraps to 0x00), wptr SHALL increment, and the FSM SHALL go to ADDR;
- otherwise the FSM SHALL go to IDLE, with busy=0 and done=1 on the same edge.
REQ-017 out_dato SHALL be registered each clk from port_id:
- offset 0: {5'b0, err, busy, done}.
- offset 1: buffer[rptr] if rptr < burst count, else 8'h00.
- offset 2: current address.
- other offsets: 8'h00.
REQ-018 A read_strobe at offset 1 with rptr < count SHALL increment rptr after that cycle; rptr SHALL saturate at count.
REQ-019 Buffer reads during a burst SHALL return only bytes already captured; otherwise the offset-1 rule of REQ-017 applies.

Reset
REQ-020 While reset=0, asynchronously: FSM=IDLE, all strobes 1, dato high-Z, busy=done=err=0, mirror_we=0, out_dato=0, address/data/pointers=0, length=1.
REQ-021 Reset asserted mid-transaction SHALL abort it immediately; buffer contents SHALL be don't-care.

Verification (T_PHASE=2, BURST_MAX=16, PORT_BASE=8'h00)
REQ-022 The bench SHALL cover these scenarios:
- Reset low during IDLE and during DATA -> strobes 1111 within the same cycle, dato Z, status 8'h00 after release.
- Addr 0x21, data 0x45, cmd 0x01 -> AD/CS/WR low 2 cycles with dato=0x21; 2 idle cycles; CS/WR low 2 cycles with dato=0x45; busy for 8 cycles; status 8'h01.
- Addr 0x21, length 3, cmd 0x02, RTC model returns 0x10/0x20/0x30 -> mirror_we pulses idx 0,1,2 every 8 cycles; offset-1 reads return 0x10,0x20,0x30, then 0x00.
- Addr 0xFF, length 2, burst -> address phases show 0xFF then 0x00.
- Length writes 0 and 20 -> bursts of 1 and 16 bytes; mirror_idx ends at 0 and 15.
- Cmd written while busy -> no new bus activity, status bit2=1; next accepted cmd clears it.
